// File: rtl/c_element_hs_driver.sv
// Synchronous 4-phase initiator for a Muller C-element: drives a/b through a full rise/fall
// handshake, checks the synchronized response, measures rise latency and counts clean handshakes.
module c_element_hs_driver #(
    parameter int          SYNC_STAGES = 2,
    parameter int          HOLD_CYC    = 4,
    parameter int          TIMEOUT     = 200,
    parameter logic [15:0] PASS_INIT   = 16'h0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [1:0]  mode_i,
    input  logic        c_i,
    output logic        a_o,
    output logic        b_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [7:0]  lat_o,
    output logic [15:0] pass_cnt_o
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SET1    = 3'd1;
    localparam logic [2:0] ST_SET2    = 3'd2;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
    localparam logic [2:0] ST_CLR1    = 3'd4;
    localparam logic [2:0] ST_CLR2    = 3'd5;
    localparam logic [2:0] ST_WAIT_LO = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    localparam logic [1:0] MODE_A  = 2'b00;
    localparam logic [1:0] MODE_B  = 2'b01;
    localparam logic [1:0] MODE_AB = 2'b10;

    localparam logic [1:0] ERR_RISE    = 2'b01;
    localparam logic [1:0] ERR_FALL    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   c_sync;

    logic [2:0]  state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  start_mode;
    logic [7:0]  cnt_q, cnt_d;
    logic        a_q, a_d;
    logic        b_q, b_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic [7:0]  lat_q, lat_d;
    logic [15:0] pass_q, pass_d;

    logic        premature;
    logic [1:0]  premature_code;
    logic        timeout;
    logic        both;

    // c_i is asynchronous; only the last stage is ever looked at by the FSM.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], c_i};
        end
    end

    assign c_sync     = sync_q[SYNC_STAGES-1];
    assign start_mode = (mode_i == 2'b11) ? MODE_A : mode_i;
    assign both       = (mode_q == MODE_AB);

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        cnt_d          = cnt_q;
        a_d            = a_q;
        b_d            = b_q;
        done_d         = 1'b0;
        err_d          = err_q;
        code_d         = code_q;
        lat_d          = lat_q;
        pass_d         = pass_q;
        premature      = 1'b0;
        premature_code = 2'b00;
        timeout        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d  = start_mode;
                    a_d     = (start_mode != MODE_B);
                    b_d     = (start_mode != MODE_A);
                    err_d   = 1'b0;
                    code_d  = 2'b00;
                    cnt_d   = 8'd0;
                    state_d = ST_SET1;
                end
            end
            ST_SET1: begin
                if (!both && c_sync) begin
                    premature      = 1'b1;
                    premature_code = ERR_RISE;
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_SET2;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SET2: begin
                a_d     = 1'b1;
                b_d     = 1'b1;
                cnt_d   = 8'd0;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                // A response arriving on the timeout cycle still counts as a success.
                if (c_sync) begin
                    lat_d   = cnt_q;
                    cnt_d   = 8'd0;
                    state_d = ST_CLR1;
                    if (both) begin
                        a_d = 1'b0;
                        b_d = 1'b0;
                    end else if (mode_q == MODE_B) begin
                        b_d = 1'b0;
                    end else begin
                        a_d = 1'b0;
                    end
                end else if (cnt_q == TIMEOUT_CNT) begin
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CLR1: begin
                if (!both && !c_sync) begin
                    premature      = 1'b1;
                    premature_code = ERR_FALL;
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_CLR2;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CLR2: begin
                a_d     = 1'b0;
                b_d     = 1'b0;
                cnt_d   = 8'd0;
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!c_sync) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                if (!err_q) begin
                    pass_d = pass_q + 16'd1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any failure releases both C-element inputs on the same edge and ends the handshake.
        if (premature || timeout) begin
            err_d   = 1'b1;
            code_d  = premature ? premature_code : ERR_TIMEOUT;
            a_d     = 1'b0;
            b_d     = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_A;
            cnt_q   <= 8'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            lat_q   <= 8'd0;
            pass_q  <= PASS_INIT;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            lat_q   <= lat_d;
            pass_q  <= pass_d;
        end
    end

    assign a_o        = a_q;
    assign b_o        = b_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;
    assign lat_o      = lat_q;
    assign pass_cnt_o = pass_q;

endmodule

// File: tb/tb_c_element_hs_driver.sv
// Bench for c_element_hs_driver: behavioural C-element with programmable delay and fault modes,
// expected results queued at stimulus time and compared when done_o pulses.
module tb_c_element_hs_driver;

    localparam int SYNC_STAGES = 2;
    localparam int HOLD_CYC    = 4;
    localparam int TIMEOUT     = 200;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode  = 2'b00;
    logic        c;
    logic        a, b, busy, done, err;
    logic [1:0]  code;
    logic [7:0]  lat;
    logic [15:0] pass;

    logic        start2 = 1'b0;
    logic [1:0]  mode2  = 2'b00;
    logic        c2     = 1'b0;
    logic        a2, b2, busy2, done2, err2;
    logic [1:0]  code2;
    logic [7:0]  lat2;
    logic [15:0] pass2;

    always #5 clk = ~clk;

    c_element_hs_driver #(
        .SYNC_STAGES(SYNC_STAGES), .HOLD_CYC(HOLD_CYC), .TIMEOUT(TIMEOUT), .PASS_INIT(16'h0000)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .mode_i(mode), .c_i(c),
        .a_o(a), .b_o(b), .busy_o(busy), .done_o(done), .err_o(err),
        .err_code_o(code), .lat_o(lat), .pass_cnt_o(pass)
    );

    // Second instance preloaded near the top of the pass counter to exercise the wrap.
    c_element_hs_driver #(
        .SYNC_STAGES(SYNC_STAGES), .HOLD_CYC(HOLD_CYC), .TIMEOUT(TIMEOUT), .PASS_INIT(16'hFFFF)
    ) dut_wrap (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start2), .mode_i(mode2), .c_i(c2),
        .a_o(a2), .b_o(b2), .busy_o(busy2), .done_o(done2), .err_o(err2),
        .err_code_o(code2), .lat_o(lat2), .pass_cnt_o(pass2)
    );

    // C-element model: kind 0 ideal, 1 faulty OR gate, 2 stuck at 0; delayed by delay_d cycles.
    int          delay_d    = 0;
    int          model_kind = 0;
    logic        c_good     = 1'b0;
    logic        c_raw;
    logic [31:0] hist       = 32'd0;

    always @(a or b) begin
        if (a == 1'b1 && b == 1'b1) c_good = 1'b1;
        else if (a == 1'b0 && b == 1'b0) c_good = 1'b0;
    end

    assign c_raw = (model_kind == 1) ? (a | b) : (model_kind == 2) ? 1'b0 : c_good;

    always @(posedge clk) hist <= {hist[30:0], c_raw};

    assign c = (delay_d == 0) ? c_raw : hist[5'(delay_d - 1)];

    always @(a2 or b2) begin
        if (a2 == 1'b1 && b2 == 1'b1) c2 = 1'b1;
        else if (a2 == 1'b0 && b2 == 1'b0) c2 = 1'b0;
    end

    int   cyc       = 0;
    int   a_rise    = 0;
    int   b_rise    = 0;
    int   done_cnt  = 0;
    int   done2_cnt = 0;
    logic a_prev    = 1'b0;
    logic b_prev    = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (a && !a_prev) a_rise = cyc;
        if (b && !b_prev) b_rise = cyc;
        a_prev = a;
        b_prev = b;
        if (done) done_cnt = done_cnt + 1;
        if (done2) done2_cnt = done2_cnt + 1;
    end

    typedef struct {
        logic        e_err;
        logic [1:0]  e_code;
        bit          chk_lat;
        logic [7:0]  e_lat;
        logic [15:0] e_pass;
    } exp_t;

    exp_t        sb[$];
    int          total      = 0;
    int          bad        = 0;
    logic [15:0] bench_pass = 16'd0;
    logic [7:0]  bench_lat  = 8'd0;

    task automatic push_and_start(input bit which, input logic [1:0] m, input bit hold3,
                                  input logic e_err, input logic [1:0] e_code, input bit chk_lat,
                                  input logic [7:0] e_lat, input logic [15:0] e_pass);
        exp_t ex;
        ex.e_err   = e_err;
        ex.e_code  = e_code;
        ex.chk_lat = chk_lat;
        ex.e_lat   = e_lat;
        ex.e_pass  = e_pass;
        sb.push_back(ex);
        @(negedge clk);
        if (which == 1'b0) begin
            mode  = m;
            start = 1'b1;
        end else begin
            start2 = 1'b1;
        end
        repeat (hold3 ? 3 : 1) @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input bit which, output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 2000; i++) begin
            if ((which == 1'b0 && done) || (which == 1'b1 && done2)) begin
                seen   = 1'b1;
                cycles = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({a, b, busy, done, err, code} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags got=%b want=0000000", {a, b, busy, done, err, code});
        end
        total++;
        if (lat !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_lat got=%0d want=0", lat);
        end
        total++;
        if (pass !== 16'd0) begin
            bad++;
            $display("[TB] FAIL reset_pass got=%0h want=0", pass);
        end
        total++;
        if (pass2 !== 16'hFFFF) begin
            bad++;
            $display("[TB] FAIL reset_pass_preload got=%0h want=ffff", pass2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_a_first(input string nm, input logic [1:0] m);
        bit   seen;
        int   n, t0, dc0;
        exp_t ex;
        model_kind = 0;
        delay_d    = 0;
        t0         = cyc;
        dc0        = done_cnt;
        bench_pass = bench_pass + 16'd1;
        bench_lat  = 8'(SYNC_STAGES);
        push_and_start(1'b0, m, 1'b0, 1'b0, 2'b00, 1'b1, bench_lat, bench_pass);
        wait_done(1'b0, seen, n);
        ex = sb.pop_front();
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL %s_done got=none want=pulse", nm); end
        total++;
        if (err !== ex.e_err || code !== ex.e_code) begin
            bad++;
            $display("[TB] FAIL %s_err got=%0b/%0b want=%0b/%0b", nm, err, code, ex.e_err, ex.e_code);
        end
        total++;
        if (lat !== ex.e_lat) begin bad++; $display("[TB] FAIL %s_lat got=%0d want=%0d", nm, lat, ex.e_lat); end
        @(negedge clk);
        total++;
        if (pass !== ex.e_pass) begin bad++; $display("[TB] FAIL %s_pass got=%0d want=%0d", nm, pass, ex.e_pass); end
        repeat (4) @(negedge clk);
        total++;
        if (done_cnt - dc0 != 1) begin bad++; $display("[TB] FAIL %s_pulses got=%0d want=1", nm, done_cnt - dc0); end
        total++;
        if (!(a_rise > t0 && b_rise > a_rise)) begin
            bad++;
            $display("[TB] FAIL %s_order got=a@%0d b@%0d want=a before b", nm, a_rise, b_rise);
        end
    endtask

    task automatic test_b_first();
        bit   seen;
        int   n, t0;
        exp_t ex;
        model_kind = 0;
        delay_d    = 5;
        t0         = cyc;
        bench_pass = bench_pass + 16'd1;
        bench_lat  = 8'(SYNC_STAGES + 5);
        push_and_start(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, bench_lat, bench_pass);
        wait_done(1'b0, seen, n);
        ex = sb.pop_front();
        total++;
        if (!seen || err !== ex.e_err) begin
            bad++;
            $display("[TB] FAIL b_first_err got=seen%0b/%0b want=seen1/%0b", seen, err, ex.e_err);
        end
        total++;
        if (lat !== ex.e_lat) begin bad++; $display("[TB] FAIL b_first_lat got=%0d want=%0d", lat, ex.e_lat); end
        @(negedge clk);
        total++;
        if (pass !== ex.e_pass) begin bad++; $display("[TB] FAIL b_first_pass got=%0d want=%0d", pass, ex.e_pass); end
        total++;
        if (!(b_rise > t0 && a_rise > b_rise)) begin
            bad++;
            $display("[TB] FAIL b_first_order got=a@%0d b@%0d want=b before a", a_rise, b_rise);
        end
        repeat (20) @(negedge clk);
        delay_d = 0;
    endtask

    task automatic test_premature_rise();
        bit   seen;
        int   n, dc0;
        exp_t ex;
        model_kind = 1;
        delay_d    = 0;
        dc0        = done_cnt;
        push_and_start(1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 8'd0, bench_pass);
        wait_done(1'b0, seen, n);
        ex = sb.pop_front();
        total++;
        if (!seen || err !== ex.e_err || code !== ex.e_code) begin
            bad++;
            $display("[TB] FAIL rise_err got=seen%0b/%0b/%0b want=seen1/%0b/%0b", seen, err, code, ex.e_err, ex.e_code);
        end
        total++;
        if ({a, b} !== 2'b00) begin bad++; $display("[TB] FAIL rise_release got=%b want=00", {a, b}); end
        @(negedge clk);
        total++;
        if (pass !== ex.e_pass) begin bad++; $display("[TB] FAIL rise_pass got=%0d want=%0d", pass, ex.e_pass); end
        repeat (8) @(negedge clk);
        total++;
        if (done_cnt - dc0 != 1) begin bad++; $display("[TB] FAIL rise_pulses got=%0d want=1", done_cnt - dc0); end
        model_kind = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit   seen;
        int   n;
        exp_t ex;
        model_kind = 2;
        delay_d    = 0;
        push_and_start(1'b0, 2'b10, 1'b0, 1'b1, 2'b11, 1'b1, bench_lat, bench_pass);
        wait_done(1'b0, seen, n);
        ex = sb.pop_front();
        total++;
        if (!seen || err !== ex.e_err || code !== ex.e_code) begin
            bad++;
            $display("[TB] FAIL timeout_err got=seen%0b/%0b/%0b want=seen1/%0b/%0b", seen, err, code, ex.e_err, ex.e_code);
        end
        total++;
        if (n < TIMEOUT || n > TIMEOUT + HOLD_CYC + 6) begin
            bad++;
            $display("[TB] FAIL timeout_cycles got=%0d want=%0d..%0d", n, TIMEOUT, TIMEOUT + HOLD_CYC + 6);
        end
        total++;
        if (lat !== ex.e_lat) begin bad++; $display("[TB] FAIL timeout_lat got=%0d want=%0d", lat, ex.e_lat); end
        model_kind = 0;
        repeat (6) @(negedge clk);
        bench_pass = bench_pass + 16'd1;
        bench_lat  = 8'(SYNC_STAGES);
        push_and_start(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, bench_lat, bench_pass);
        total++;
        if (err !== 1'b0 || code !== 2'b00) begin
            bad++;
            $display("[TB] FAIL restart_clear got=%0b/%0b want=0/0", err, code);
        end
        wait_done(1'b0, seen, n);
        ex = sb.pop_front();
        @(negedge clk);
        total++;
        if (!seen || err !== ex.e_err || pass !== ex.e_pass) begin
            bad++;
            $display("[TB] FAIL restart_pass got=seen%0b/%0b/%0d want=seen1/%0b/%0d", seen, err, pass, ex.e_err, ex.e_pass);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        int dc0;
        model_kind = 0;
        delay_d    = 5;
        push_and_start(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0, bench_pass + 16'd1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (a && b) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL midrst_reach got=none want=a&b high"); end
        @(negedge clk);
        rst = 1'b1;
        dc0 = done_cnt;
        @(negedge clk);
        total++;
        if ({a, b, busy, done} !== 4'b0000 || pass !== 16'd0) begin
            bad++;
            $display("[TB] FAIL midrst_state got=%b pass=%0d want=0000 pass=0", {a, b, busy, done}, pass);
        end
        rst = 1'b0;
        sb.delete();
        bench_pass = 16'd0;
        repeat (40) @(negedge clk);
        total++;
        if (done_cnt != dc0) begin bad++; $display("[TB] FAIL midrst_nodone got=%0d want=%0d", done_cnt, dc0); end
        delay_d = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wrap_single_start();
        bit          seen;
        int          n, dc0;
        exp_t        ex;
        logic [15:0] p2;
        p2  = 16'hFFFF;
        dc0 = done2_cnt;
        total++;
        if (pass2 !== p2) begin bad++; $display("[TB] FAIL wrap_pre got=%0h want=%0h", pass2, p2); end
        p2 = p2 + 16'd1;
        push_and_start(1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 8'(SYNC_STAGES), p2);
        wait_done(1'b1, seen, n);
        ex = sb.pop_front();
        total++;
        if (!seen || err2 !== ex.e_err || lat2 !== ex.e_lat) begin
            bad++;
            $display("[TB] FAIL wrap_err got=seen%0b/%0b/%0d want=seen1/%0b/%0d", seen, err2, lat2, ex.e_err, ex.e_lat);
        end
        @(negedge clk);
        total++;
        if (pass2 !== ex.e_pass) begin bad++; $display("[TB] FAIL wrap_pass got=%0h want=%0h", pass2, ex.e_pass); end
        repeat (30) @(negedge clk);
        total++;
        if (done2_cnt - dc0 != 1 || busy2 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wrap_single got=%0d busy=%0b want=1 busy=0", done2_cnt - dc0, busy2);
        end
    endtask

    initial begin
        $display("[TB] starting c_element_hs_driver bench");
        test_reset();
        test_a_first("a_first", 2'b00);
        test_b_first();
        test_premature_rise();
        test_timeout();
        test_reset_mid();
        test_a_first("reserved_mode", 2'b11);
        test_wrap_single_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=running want=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
